// File: rtl/irrigation_pkg.sv
// Shared types and helpers for the irrigation sequencer.
package irrigation_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAMPLE   = 3'd1,
    SETTLE   = 3'd2,
    DECIDE   = 3'd3,
    WATER    = 3'd4,
    COOLDOWN = 3'd5
  } state_t;

  typedef logic [7:0] sec_t;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] lim);
    return (v >= lim) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/irrigation_scheduler_sec_tick_gen.sv
// One-second tick prescaler; restarts from zero whenever clear is high.
module sec_tick_gen #(
  parameter int unsigned CLK_FREQ_HZ = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           cnt <= '0;
    else if (clear || tick) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/irrigation_scheduler.sv
// Irrigation sequencer: sample request, settle, decide, water, cooldown.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 50000000,
  parameter int unsigned SAMPLE_PERIOD_S = 60,
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned SAMPLE_TIMEOUT  = 1024,
  parameter int unsigned COOLDOWN_S      = 10,
  parameter int unsigned MAX_IRR_S       = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        manual_start,
  input  logic        abort,
  input  logic        sensor_valid,
  input  logic [7:0]  irrigation_time,
  input  logic        rain_present,
  output logic        sample_req,
  output logic        valve_on,
  output logic        busy,
  output logic [2:0]  state,
  output logic [7:0]  remaining_s,
  output logic [15:0] water_count,
  output logic [7:0]  rain_skip_count,
  output logic        sensor_timeout
);

  localparam int unsigned IW   = (SAMPLE_PERIOD_S > 0) ? $clog2(SAMPLE_PERIOD_S + 1) : 1;
  localparam int unsigned WMAX = (SAMPLE_TIMEOUT > SETTLE_CYCLES) ? SAMPLE_TIMEOUT : SETTLE_CYCLES;
  localparam int unsigned WW   = (WMAX > 0) ? $clog2(WMAX + 1) : 1;
  localparam sec_t COOL = sec_t'(COOLDOWN_S);
  localparam sec_t MAXC = sec_t'(MAX_IRR_S);

  state_t        st, st_nxt;
  logic [IW-1:0] interval, interval_nxt;
  logic [WW-1:0] wcnt;
  sec_t          rem_nxt, dur;
  logic [15:0]   wc_nxt, wc_inc;
  logic [7:0]    rsc_nxt, rsc_inc;
  logic          to_nxt;
  logic          tick, period_done, sample_expired, settle_done, water_done, cool_done;

  sec_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (st_nxt != st),
    .tick    (tick)
  );

  assign dur            = (irrigation_time > MAXC) ? MAXC : irrigation_time;
  assign wc_inc         = sat_inc(water_count, 16'hFFFF);
  assign rsc_inc        = 8'(sat_inc({8'h00, rain_skip_count}, 16'd255));
  assign period_done    = tick && (32'(interval) + 1 >= SAMPLE_PERIOD_S);
  assign sample_expired = (32'(wcnt) + 1 >= SAMPLE_TIMEOUT);
  assign settle_done    = (32'(wcnt) + 1 >= SETTLE_CYCLES);
  assign water_done     = tick && (remaining_s == 8'd1);
  assign cool_done      = (remaining_s == '0) || (tick && remaining_s == 8'd1);
  assign state          = st;

  always_comb begin
    st_nxt       = st;
    interval_nxt = interval;
    rem_nxt      = remaining_s;
    wc_nxt       = water_count;
    rsc_nxt      = rain_skip_count;
    to_nxt       = sensor_timeout;
    if (!enable) begin
      st_nxt  = IDLE;
      rem_nxt = '0;
    end else begin
      case (st)
        IDLE: begin
          if (manual_start || period_done) begin
            st_nxt       = SAMPLE;
            interval_nxt = '0;
          end else if (tick) begin
            interval_nxt = interval + 1'b1;
          end
        end
        SAMPLE: begin
          if (sensor_valid) begin
            to_nxt = 1'b0;
            st_nxt = SETTLE;
          end else if (sample_expired) begin
            to_nxt = 1'b1;
            st_nxt = IDLE;
          end
        end
        SETTLE: if (settle_done) st_nxt = DECIDE;
        DECIDE: begin
          if (rain_present) begin
            rsc_nxt = rsc_inc;
            st_nxt  = IDLE;
          end else if (dur != '0) begin
            rem_nxt = dur;
            st_nxt  = WATER;
          end else begin
            st_nxt = IDLE;
          end
        end
        WATER: begin
          // abort outranks rain, rain outranks the final tick
          if (abort || rain_present || water_done) begin
            if (!abort) begin
              if (rain_present) rsc_nxt = rsc_inc;
              else              wc_nxt  = wc_inc;
            end
            st_nxt  = COOLDOWN;
            rem_nxt = COOL;
          end else if (tick) begin
            rem_nxt = remaining_s - 1'b1;
          end
        end
        COOLDOWN: begin
          if (cool_done) begin
            st_nxt  = IDLE;
            rem_nxt = '0;
          end else if (tick) begin
            rem_nxt = remaining_s - 1'b1;
          end
        end
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st              <= IDLE;
      interval        <= '0;
      wcnt            <= '0;
      remaining_s     <= '0;
      water_count     <= '0;
      rain_skip_count <= '0;
      sensor_timeout  <= 1'b0;
      sample_req      <= 1'b0;
      valve_on        <= 1'b0;
      busy            <= 1'b0;
    end else begin
      st              <= st_nxt;
      interval        <= interval_nxt;
      remaining_s     <= rem_nxt;
      water_count     <= wc_nxt;
      rain_skip_count <= rsc_nxt;
      sensor_timeout  <= to_nxt;
      sample_req      <= (st_nxt == SAMPLE);
      valve_on        <= (st_nxt == WATER);
      busy            <= (st_nxt != IDLE);
      if (st_nxt != st)                    wcnt <= '0;
      else if (st == SAMPLE || st == SETTLE) wcnt <= wcnt + 1'b1;
    end
  end

endmodule
